// File: rtl/alpharetz_alu_arbiter.sv
// -----------------------------------------------------------------------------
// alpharetz_alu_arbiter
//
// Round-robin arbiter/sequencer sharing one alpharetz_alu between NUM_REQ
// requesters. One operation is in flight at a time:
//   IDLE  -> pick a winner, accept its operands into op registers
//   ISSUE -> drive the ALU from the op registers, capture its result
//   RESP  -> present result/flags to the winner until it accepts
// The ALU itself sits next to this block; only its operand/result ports are
// seen here.
//
// Optional feature macro: ALPHARETZ_ALU_ARB_LOCK_EN
//   Defined   : a requester holding req_lock at its response handshake keeps
//               exclusive access for its next operation, which takes its
//               carry-in from the carry flag of the previous response.
//   Undefined : req_lock is ignored.
//
// Ports
//   clk, async_rst_n         clock, asynchronous active-low reset
//   clk_en, sys_en           FSM advances only when both are high
//   req_valid/req_ready      per-requester request handshake (ready one-hot)
//   req_opcode/s_imm/src_1/src_2/carry_in/lock  packed per-requester operands
//   resp_valid/resp_ready    per-requester response handshake (valid one-hot)
//   resp_result/resp_flags   shared response buses
//   alu_*                    ALU operand drive and ALU result/flag inputs
// -----------------------------------------------------------------------------
module alpharetz_alu_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int CPU_DATA_WIDTH  = 32,
  parameter int OPCODE_WIDTH    = 6,
  parameter int SHORT_IMM_WIDTH = 5,
  parameter int FLAG_REG_WIDTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 async_rst_n,
  input  logic                                 clk_en,
  input  logic                                 sys_en,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*OPCODE_WIDTH-1:0]      req_opcode,
  input  logic [NUM_REQ*SHORT_IMM_WIDTH-1:0]   req_s_imm,
  input  logic [NUM_REQ*CPU_DATA_WIDTH-1:0]    req_src_1,
  input  logic [NUM_REQ*CPU_DATA_WIDTH-1:0]    req_src_2,
  input  logic [NUM_REQ-1:0]                   req_carry_in,
  input  logic [NUM_REQ-1:0]                   req_lock,
  output logic [NUM_REQ-1:0]                   resp_valid,
  input  logic [NUM_REQ-1:0]                   resp_ready,
  output logic [CPU_DATA_WIDTH-1:0]            resp_result,
  output logic [FLAG_REG_WIDTH-1:0]            resp_flags,
  output logic [OPCODE_WIDTH-1:0]              alu_opcode,
  output logic [SHORT_IMM_WIDTH-1:0]           alu_s_imm,
  output logic [CPU_DATA_WIDTH-1:0]            alu_src_1,
  output logic [CPU_DATA_WIDTH-1:0]            alu_src_2,
  output logic                                 alu_carry_in,
  input  logic [CPU_DATA_WIDTH-1:0]            alu_result,
  input  logic [FLAG_REG_WIDTH-1:0]            alu_flag_reg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t                     r_state;
  logic [PTR_W-1:0]           r_rr_ptr;
  logic [PTR_W-1:0]           r_grant;
  logic [OPCODE_WIDTH-1:0]    r_op_opcode;
  logic [SHORT_IMM_WIDTH-1:0] r_op_s_imm;
  logic [CPU_DATA_WIDTH-1:0]  r_op_src_1;
  logic [CPU_DATA_WIDTH-1:0]  r_op_src_2;
  logic                       r_op_carry;
  logic [CPU_DATA_WIDTH-1:0]  r_resp_result;

  logic                       w_adv;
  logic [NUM_REQ-1:0]         w_eligible;
  logic                       w_hi_found;
  logic [PTR_W-1:0]           w_hi_idx;
  logic                       w_lo_found;
  logic [PTR_W-1:0]           w_lo_idx;
  logic                       w_found;
  logic [PTR_W-1:0]           w_winner;
  logic [PTR_W-1:0]           w_next_ptr;
  logic                       w_busy;

  logic [OPCODE_WIDTH-1:0]    w_op_arr    [NUM_REQ];
  logic [SHORT_IMM_WIDTH-1:0] w_simm_arr  [NUM_REQ];
  logic [CPU_DATA_WIDTH-1:0]  w_src1_arr  [NUM_REQ];
  logic [CPU_DATA_WIDTH-1:0]  w_src2_arr  [NUM_REQ];

`ifdef ALPHARETZ_ALU_ARB_LOCK_EN
  logic                       r_locked;
  logic                       r_prev_carry;
`else
  logic                       w_unused_lock;
  assign w_unused_lock = ^req_lock;
`endif

  assign w_adv = clk_en & sys_en;

  // Unpack the per-requester operand buses.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_op_arr[gi]   = req_opcode[gi*OPCODE_WIDTH +: OPCODE_WIDTH];
      assign w_simm_arr[gi] = req_s_imm[gi*SHORT_IMM_WIDTH +: SHORT_IMM_WIDTH];
      assign w_src1_arr[gi] = req_src_1[gi*CPU_DATA_WIDTH +: CPU_DATA_WIDTH];
      assign w_src2_arr[gi] = req_src_2[gi*CPU_DATA_WIDTH +: CPU_DATA_WIDTH];
    end
  endgenerate

  // Eligibility mask: while locked only the lock holder may win.
  always_comb begin
`ifdef ALPHARETZ_ALU_ARB_LOCK_EN
    w_eligible = r_locked ? (req_valid & f_onehot(r_grant)) : req_valid;
`else
    w_eligible = req_valid;
`endif
  end

  // Round-robin search. Scanning downward means the last hit is the lowest
  // index; the "hi" search only accepts indices at or above the pointer, and
  // the unrestricted "lo" search provides the wrap-around candidate.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      w_lo_found = w_eligible[j] ? 1'b1 : w_lo_found;
      w_lo_idx   = w_eligible[j] ? PTR_W'(j) : w_lo_idx;
      w_hi_found = (w_eligible[j] && (PTR_W'(j) >= r_rr_ptr)) ? 1'b1 : w_hi_found;
      w_hi_idx   = (w_eligible[j] && (PTR_W'(j) >= r_rr_ptr)) ? PTR_W'(j) : w_hi_idx;
    end
    w_found    = w_hi_found | w_lo_found;
    w_winner   = w_hi_found ? w_hi_idx : w_lo_idx;
    w_next_ptr = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : (w_winner + {{(PTR_W-1){1'b0}}, 1'b1});
  end

  // Sequencer FSM and all datapath registers; frozen whenever adv is low.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_op_opcode   <= '0;
      r_op_s_imm    <= '0;
      r_op_src_1    <= '0;
      r_op_src_2    <= '0;
      r_op_carry    <= 1'b0;
      r_resp_result <= '0;
`ifdef ALPHARETZ_ALU_ARB_LOCK_EN
      r_locked      <= 1'b0;
      r_prev_carry  <= 1'b0;
`endif
    end else if (w_adv) begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant     <= w_winner;
            r_op_opcode <= w_op_arr[w_winner];
            r_op_s_imm  <= w_simm_arr[w_winner];
            r_op_src_1  <= w_src1_arr[w_winner];
            r_op_src_2  <= w_src2_arr[w_winner];
`ifdef ALPHARETZ_ALU_ARB_LOCK_EN
            // A locked follow-on chains the carry of the previous result.
            r_op_carry  <= r_locked ? r_prev_carry : req_carry_in[w_winner];
            r_rr_ptr    <= r_locked ? r_rr_ptr : w_next_ptr;
`else
            r_op_carry  <= req_carry_in[w_winner];
            r_rr_ptr    <= w_next_ptr;
`endif
            r_state     <= ISSUE;
          end else begin
            r_state     <= IDLE;
          end
        end
        ISSUE: begin
          r_resp_result <= alu_result;
          r_state       <= RESP;
        end
        RESP: begin
          if (resp_ready[r_grant]) begin
`ifdef ALPHARETZ_ALU_ARB_LOCK_EN
            r_locked     <= req_lock[r_grant];
            r_prev_carry <= alu_flag_reg[1];
`endif
            r_state      <= IDLE;
          end else begin
            r_state      <= RESP;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  // Output drive: ALU operands only while an operation is in flight, grant
  // only in IDLE on an advancing cycle, response while in RESP.
  always_comb begin
    w_busy       = (r_state == ISSUE) || (r_state == RESP);
    alu_opcode   = w_busy ? r_op_opcode : '0;
    alu_s_imm    = w_busy ? r_op_s_imm  : '0;
    alu_src_1    = w_busy ? r_op_src_1  : '0;
    alu_src_2    = w_busy ? r_op_src_2  : '0;
    alu_carry_in = w_busy ? r_op_carry  : 1'b0;
    req_ready    = ((r_state == IDLE) && w_adv && w_found) ? f_onehot(w_winner) : '0;
    resp_valid   = (r_state == RESP) ? f_onehot(r_grant) : '0;
    resp_flags   = (r_state == RESP) ? alu_flag_reg : '0;
  end

  assign resp_result = r_resp_result;

endmodule

// File: tb/tb_alpharetz_alu_arbiter.sv
module tb_alpharetz_alu_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int OW = 6;
  localparam int IW = 5;
  localparam int FW = 8;

  typedef struct {
    int          idx;
    logic [DW-1:0] res;
    logic [FW-1:0] flg;
  } exp_t;

  logic              clk;
  logic              async_rst_n;
  logic              clk_en;
  logic              sys_en;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*OW-1:0]  req_opcode;
  logic [NR*IW-1:0]  req_s_imm;
  logic [NR*DW-1:0]  req_src_1;
  logic [NR*DW-1:0]  req_src_2;
  logic [NR-1:0]     req_carry_in;
  logic [NR-1:0]     req_lock;
  logic [NR-1:0]     resp_valid;
  logic [NR-1:0]     resp_ready;
  logic [DW-1:0]     resp_result;
  logic [FW-1:0]     resp_flags;
  logic [OW-1:0]     alu_opcode;
  logic [IW-1:0]     alu_s_imm;
  logic [DW-1:0]     alu_src_1;
  logic [DW-1:0]     alu_src_2;
  logic              alu_carry_in;
  logic [DW-1:0]     alu_result;
  logic [FW-1:0]     alu_flag_reg = '0;
  logic              m_carry;

  logic [DW-1:0]     exp_res [NR];
  logic [FW-1:0]     exp_flg [NR];
  exp_t              sb[$];
  int                grant_log[$];
  int                checks = 0;
  int                failures = 0;

  alpharetz_alu_arbiter #(
    .NUM_REQ(NR), .CPU_DATA_WIDTH(DW), .OPCODE_WIDTH(OW),
    .SHORT_IMM_WIDTH(IW), .FLAG_REG_WIDTH(FW)
  ) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .sys_en(sys_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_s_imm(req_s_imm), .req_src_1(req_src_1), .req_src_2(req_src_2),
    .req_carry_in(req_carry_in), .req_lock(req_lock),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .alu_opcode(alu_opcode), .alu_s_imm(alu_s_imm), .alu_src_1(alu_src_1),
    .alu_src_2(alu_src_2), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_flag_reg(alu_flag_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: opcode 1 = add with carry, anything else = NOP (0).
  always_comb begin
    m_carry    = 1'b0;
    alu_result = '0;
    case (alu_opcode)
      6'd1:    {m_carry, alu_result} = {1'b0, alu_src_1} + {1'b0, alu_src_2} + {{DW{1'b0}}, alu_carry_in};
      default: begin m_carry = 1'b0; alu_result = '0; end
    endcase
  end

  // Registered flags: bit0 zero, bit1 carry.
  always @(posedge clk) alu_flag_reg <= {6'd0, m_carry, (alu_result == '0)};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [OW-1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic cin,
                         input logic [DW-1:0] res, input logic [FW-1:0] flg);
    req_opcode[idx*OW +: OW] = op;
    req_src_1[idx*DW +: DW]  = a;
    req_src_2[idx*DW +: DW]  = b;
    req_carry_in[idx]        = cin;
    exp_res[idx]             = res;
    exp_flg[idx]             = flg;
  endtask

  // Wait (bounded) for req_ready[idx]; returns just after the handshake edge.
  task automatic wait_grant(input int idx, input bit drop);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1'b1;
    end
    chk($sformatf("grant_req%0d", idx), {63'd0, got}, 64'd1);
    @(posedge clk);
    #1;
    if (drop) req_valid[idx] = 1'b0;
  endtask

  task automatic wait_grants(input int target);
    for (int n = 0; n < 60 && grant_log.size() < target; n++) tick();
    chk("grant_count", grant_log.size(), target);
  endtask

  task automatic wait_sb_empty();
    for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
    chk("sb_empty", sb.size(), 0);
  endtask

  // Scoreboard: push expectations on accepted requests, pop on responses.
  task automatic monitor_loop();
    exp_t e;
    int   gidx;
    logic [NR-1:0] oh;
    forever begin
      @(negedge clk);
      if (!async_rst_n) begin
        sb.delete();
      end else if (clk_en && sys_en) begin
        if (req_ready != '0) begin
          gidx = 0;
          for (int k = 0; k < NR; k++) if (req_ready[k]) gidx = k;
          e.idx = gidx;
          e.res = exp_res[gidx];
          e.flg = exp_flg[gidx];
          sb.push_back(e);
          grant_log.push_back(gidx);
        end
        if ((resp_valid & resp_ready) != '0) begin
          if (sb.size() == 0) begin
            chk("resp_unexpected", {60'd0, resp_valid}, 64'd0);
          end else begin
            e  = sb.pop_front();
            oh = 4'b0001 << e.idx;
            chk("resp_valid", {60'd0, resp_valid}, {60'd0, oh});
            chk("resp_result", {32'd0, resp_result}, {32'd0, e.res});
            chk("resp_flags", {56'd0, resp_flags}, {56'd0, e.flg});
          end
        end
      end
    end
  endtask

  int g0;

  initial begin
    async_rst_n  = 1'b0;
    clk_en       = 1'b1;
    sys_en       = 1'b1;
    req_valid    = '0;
    req_opcode   = '0;
    req_s_imm    = '0;
    req_src_1    = '0;
    req_src_2    = '0;
    req_carry_in = '0;
    req_lock     = '0;
    resp_ready   = '1;
    for (int i = 0; i < NR; i++) begin exp_res[i] = '0; exp_flg[i] = '0; end
    fork
      monitor_loop();
    join_none

    // Reset state
    #2;
    chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {60'd0, resp_valid}, 64'd0);
    chk("rst_resp_result", {32'd0, resp_result}, 64'd0);
    chk("rst_resp_flags", {56'd0, resp_flags}, 64'd0);
    chk("rst_alu_opcode", {58'd0, alu_opcode}, 64'd0);
    chk("rst_alu_src_1", {32'd0, alu_src_1}, 64'd0);
    tick(); tick();
    async_rst_n = 1'b1;
    tick();

    // Single request: requester 2, 5 + 7
    set_req(2, 6'd1, 32'd5, 32'd7, 1'b0, 32'd12, 8'h00);
    req_s_imm[2*IW +: IW] = 5'd3;
    req_valid[2] = 1'b1;
    wait_grant(2, 1'b1);
    chk("t1_issue_resp_valid", {60'd0, resp_valid}, 64'd0);
    chk("t1_alu_opcode", {58'd0, alu_opcode}, 64'd1);
    chk("t1_alu_s_imm", {59'd0, alu_s_imm}, 64'd3);
    chk("t1_alu_src_1", {32'd0, alu_src_1}, 64'd5);
    chk("t1_alu_src_2", {32'd0, alu_src_2}, 64'd7);
    tick();
    chk("t1_resp_valid", {60'd0, resp_valid}, 64'b0100);
    chk("t1_resp_result", {32'd0, resp_result}, 64'd12);
    chk("t1_zero_flag", {63'd0, resp_flags[0]}, 64'd0);
    tick();
    chk("t1_idle_resp_valid", {60'd0, resp_valid}, 64'd0);
    wait_sb_empty();

    // All four valid continuously from reset: grants 0,1,2,3,0
    async_rst_n = 1'b0;
    tick(); tick();
    async_rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 6'd1, 32'(i*16 + 1), 32'd2, 1'b0, 32'(i*16 + 3), 8'h00);
    g0 = grant_log.size();
    req_valid = '1;
    wait_grants(g0 + 5);
    req_valid = '0;
    chk("t2_grant0", grant_log[g0], 64'd0);
    chk("t2_grant1", grant_log[g0+1], 64'd1);
    chk("t2_grant2", grant_log[g0+2], 64'd2);
    chk("t2_grant3", grant_log[g0+3], 64'd3);
    chk("t2_grant_wrap", grant_log[g0+4], 64'd0);
    wait_sb_empty();

    // Back-pressure on requester 1 while requester 0 waits
    resp_ready[1] = 1'b0;
    set_req(1, 6'd1, 32'd100, 32'd23, 1'b0, 32'd123, 8'h00);
    set_req(0, 6'd1, 32'd3, 32'd4, 1'b0, 32'd7, 8'h00);
    req_valid[1] = 1'b1;
    wait_grant(1, 1'b1);
    req_valid[0] = 1'b1;
    tick();
    chk("t3_resp_valid", {60'd0, resp_valid}, 64'b0010);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_hold_valid", {60'd0, resp_valid}, 64'b0010);
      chk("t3_hold_result", {32'd0, resp_result}, 64'd123);
      chk("t3_no_grant", {60'd0, req_ready}, 64'd0);
    end
    resp_ready[1] = 1'b1;
    tick();
    chk("t3_idle_resp_valid", {60'd0, resp_valid}, 64'd0);
    chk("t3_idle_grant0", {60'd0, req_ready}, 64'b0001);
    tick();
    req_valid[0] = 1'b0;
    wait_sb_empty();

    // clk_en low for 3 cycles in ISSUE
    set_req(3, 6'd1, 32'h1000, 32'h0234, 1'b0, 32'h1234, 8'h00);
    req_valid[3] = 1'b1;
    wait_grant(3, 1'b1);
    clk_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_frozen_resp_valid", {60'd0, resp_valid}, 64'd0);
      chk("t4_frozen_opcode", {58'd0, alu_opcode}, 64'd1);
    end
    clk_en = 1'b1;
    tick();
    chk("t4_resp_valid", {60'd0, resp_valid}, 64'b1000);
    chk("t4_resp_result", {32'd0, resp_result}, 64'h1234);
    wait_sb_empty();

    // Reset mid-RESP
    resp_ready[2] = 1'b0;
    set_req(2, 6'd1, 32'd9, 32'd9, 1'b0, 32'd18, 8'h00);
    req_valid[2] = 1'b1;
    wait_grant(2, 1'b1);
    tick();
    chk("t5_resp_valid", {60'd0, resp_valid}, 64'b0100);
    async_rst_n = 1'b0;
    #1;
    chk("t5_rst_resp_valid", {60'd0, resp_valid}, 64'd0);
    chk("t5_rst_resp_result", {32'd0, resp_result}, 64'd0);
    chk("t5_rst_alu_opcode", {58'd0, alu_opcode}, 64'd0);
    chk("t5_rst_alu_src_1", {32'd0, alu_src_1}, 64'd0);
    tick(); tick();
    async_rst_n = 1'b1;
    resp_ready = '1;
    set_req(0, 6'd1, 32'd1, 32'd1, 1'b0, 32'd2, 8'h00);
    set_req(3, 6'd1, 32'd2, 32'd2, 1'b0, 32'd4, 8'h00);
    g0 = grant_log.size();
    req_valid = 4'b1001;
    wait_grants(g0 + 1);
    req_valid[0] = 1'b0;
    wait_grants(g0 + 2);
    req_valid[3] = 1'b0;
    chk("t5_first_grant", grant_log[g0], 64'd0);
    chk("t5_second_grant", grant_log[g0+1], 64'd3);
    wait_sb_empty();

`ifdef ALPHARETZ_ALU_ARB_LOCK_EN
    // Locked chain on requester 1 blocks requester 3
    set_req(1, 6'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 8'h03);
    set_req(3, 6'd1, 32'd5, 32'd5, 1'b0, 32'd10, 8'h00);
    req_lock[1] = 1'b1;
    g0 = grant_log.size();
    req_valid = 4'b1010;
    wait_grant(1, 1'b0);
    set_req(1, 6'd1, 32'd0, 32'd0, 1'b0, 32'd1, 8'h00);
    wait_grants(g0 + 2);
    chk("t6_locked_grant", grant_log[g0+1], 64'd1);
    chk("t6_chained_carry", {63'd0, alu_carry_in}, 64'd1);
    req_lock[1]  = 1'b0;
    req_valid[1] = 1'b0;
    wait_grants(g0 + 3);
    req_valid[3] = 1'b0;
    chk("t6_first_grant", grant_log[g0], 64'd1);
    chk("t6_after_unlock", grant_log[g0+2], 64'd3);
    wait_sb_empty();
`endif

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
